// File: rtl/om_packer.sv
// om_packer
//   Output-memory packer feeding the OM write-buffer register stage.
//   Each accepted signed accumulator result is rounded, arithmetically shifted
//   right and saturated to a 16-bit lane. Four lanes are packed into one
//   64-bit OMEM word, which is written at an incrementing, wrapping address.
//
// Ports
//   CLK          in   clock, rising edge
//   RSTN         in   asynchronous active-low reset
//   start        in   job start pulse, honoured only when idle
//   shift        in   right-shift amount, captured at start
//   acc_valid    in   acc_data valid this cycle
//   acc_data     in   signed accumulator result
//   acc_last     in   final element of the job (qualified by acc_valid)
//   ODST_o       out  OMEM word address
//   OMWrite_o    out  OMEM write strobe, single-cycle pulse
//   OMEM_Data_o  out  packed word, lane k = bits[16k+15:16k]
//   busy         out  high while packing a job
//   done         out  single-cycle pulse after the final write of a job
//   sat          out  sticky saturation flag for the current job
module om_packer #(
  parameter int ACC_W  = 32,
  parameter int LANE_W = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     start,
  input  logic [4:0]               shift,
  input  logic                     acc_valid,
  input  logic [ACC_W-1:0]         acc_data,
  input  logic                     acc_last,
  output logic [ADDR_W-1:0]        ODST_o,
  output logic                     OMWrite_o,
  output logic [LANES*LANE_W-1:0]  OMEM_Data_o,
  output logic                     busy,
  output logic                     done,
  output logic                     sat
);

  localparam int CNT_W  = $clog2(LANES);
  localparam int WORD_W = LANES * LANE_W;
  localparam int EXT_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [4:0]          shift_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [CNT_W-1:0]    lane_cnt_r;
  logic [WORD_W-1:0]   pack_r;
  logic [WORD_W-1:0]   pack_s;
  logic [LANE_W:0]     conv_s;
  logic [LANE_W-1:0]   lane_s;
  logic                lane_sat_s;
  logic                accept_s;
  logic                flush_s;

  // Round-half-up, arithmetic right shift and saturate one accumulator value.
  // Worked at ACC_W+1 bits so adding the rounding constant cannot overflow.
  // Result is {saturated, lane}.
  function automatic logic [LANE_W:0] rescale(input logic [ACC_W-1:0] acc,
                                              input logic [4:0]       sh);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] t;
    logic signed [EXT_W-1:0] lane_max;
    logic signed [EXT_W-1:0] lane_min;
    ext      = {acc[ACC_W-1], acc};
    lane_max = {{(EXT_W-LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
    lane_min = {{(EXT_W-LANE_W+1){1'b1}}, {(LANE_W-1){1'b0}}};
    if (sh != 5'd0) begin
      rnd = {{(EXT_W-1){1'b0}}, 1'b1} << (sh - 5'd1);
    end else begin
      rnd = '0;
    end
    t = (ext + rnd) >>> sh;
    if (t > lane_max) begin
      return {1'b1, 1'b0, {(LANE_W-1){1'b1}}};
    end else if (t < lane_min) begin
      return {1'b1, 1'b1, {(LANE_W-1){1'b0}}};
    end else begin
      return {1'b0, t[LANE_W-1:0]};
    end
  endfunction

  // Convert the incoming element and merge it into the current word.
  always_comb begin
    conv_s     = rescale(acc_data, shift_r);
    lane_s     = conv_s[LANE_W-1:0];
    lane_sat_s = conv_s[LANE_W];
    pack_s     = pack_r;
    pack_s[int'(lane_cnt_r)*LANE_W +: LANE_W] = lane_s;
    accept_s   = (state_r == ST_PACK) && acc_valid;
    // A word goes out when its last lane fills or the job ends early.
    flush_s    = accept_s && ((lane_cnt_r == CNT_W'(LANES-1)) || acc_last);
  end

  // Job sequencing: next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_PACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PACK: begin
        if (accept_s && acc_last) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_PACK;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Job sequencing: state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pack register, lane/address counters and all registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      shift_r     <= 5'd0;
      addr_r      <= '0;
      lane_cnt_r  <= '0;
      pack_r      <= '0;
      ODST_o      <= '0;
      OMWrite_o   <= 1'b0;
      OMEM_Data_o <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sat         <= 1'b0;
    end else begin
      OMWrite_o <= 1'b0;
      // done trails the DONE state by a cycle so it lands after the last write.
      done      <= (state_r == ST_DONE);
      busy      <= (state_s == ST_PACK);
      if ((state_r == ST_IDLE) && start) begin
        shift_r    <= shift;
        addr_r     <= '0;
        lane_cnt_r <= '0;
        pack_r     <= '0;
        sat        <= 1'b0;
      end else if (accept_s) begin
        if (lane_sat_s) begin
          sat <= 1'b1;
        end
        if (flush_s) begin
          OMWrite_o   <= 1'b1;
          ODST_o      <= addr_r;
          OMEM_Data_o <= pack_s;
          pack_r      <= '0;
          lane_cnt_r  <= '0;
          addr_r      <= addr_r + ADDR_W'(1);
        end else begin
          pack_r     <= pack_s;
          lane_cnt_r <= lane_cnt_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_om_packer.sv
// tb_om_packer
//   Scoreboard bench for om_packer: stimulus pushes hand-computed
//   {address, word} pairs into a queue, and a monitor pops and compares them
//   whenever OMWrite_o is seen.
module tb_om_packer;

  logic        CLK;
  logic        RSTN;
  logic        start;
  logic [4:0]  shift;
  logic        acc_valid;
  logic [31:0] acc_data;
  logic        acc_last;
  logic [3:0]  ODST_o;
  logic        OMWrite_o;
  logic [63:0] OMEM_Data_o;
  logic        busy;
  logic        done;
  logic        sat;

  int tests = 0;
  int fails = 0;
  logic [67:0] exp_q[$];

  om_packer dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .shift(shift),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_last(acc_last),
    .ODST_o(ODST_o), .OMWrite_o(OMWrite_o), .OMEM_Data_o(OMEM_Data_o),
    .busy(busy), .done(done), .sat(sat)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected entry.
  always @(negedge CLK) begin
    if (OMWrite_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", ODST_o, OMEM_Data_o);
      end else begin
        logic [67:0] e;
        e = exp_q.pop_front();
        check("write_addr", 64'(ODST_o), 64'(e[67:64]));
        check("write_data", OMEM_Data_o, e[63:0]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_job(input logic [4:0] sh);
    start = 1'b1;
    shift = sh;
    tick();
    start = 1'b0;
    shift = 5'd0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    acc_valid = 1'b1;
    acc_data  = d;
    acc_last  = last;
    tick();
    acc_valid = 1'b0;
    acc_data  = 32'd0;
    acc_last  = 1'b0;
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [63:0] d);
    exp_q.push_back({a, d});
  endtask

  // Call right after the send carrying acc_last returns.
  task automatic finish_job(input string name);
    check({name, "_done_early"}, 64'(done), 64'd0);
    tick();
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    tick();
    check({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_odst"}, 64'(ODST_o), 64'd0);
    check({name, "_wr"}, 64'(OMWrite_o), 64'd0);
    check({name, "_data"}, OMEM_Data_o, 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_sat"}, 64'(sat), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN      = 1'b0;
    start     = 1'b0;
    shift     = 5'd0;
    acc_valid = 1'b0;
    acc_data  = 32'd0;
    acc_last  = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      start     = i[0];
      acc_valid = ~i[0];
      acc_last  = i[1];
      acc_data  = 32'h1234_0000 + 32'(i);
      tick();
    end
    check_reset_outputs("reset");
    RSTN = 1'b1;
    // Activity in IDLE must not produce writes (monitor flags any).
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc_valid = 1'b1;
      acc_last  = i[0];
      acc_data  = 32'(i + 7);
      tick();
    end
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);

    // One full word.
    start_job(5'd0);
    check("basic_busy", 64'(busy), 64'd1);
    expect_write(4'd0, 64'h0004_0003_0002_0001);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    send(32'd4, 1'b1);
    finish_job("basic");

    // Full word followed by a partial word.
    start_job(5'd0);
    expect_write(4'd0, 64'h000D_000C_000B_000A);
    expect_write(4'd1, 64'h0000_0000_000F_000E);
    for (int i = 10; i < 16; i++) send(32'(i), (i == 15));
    finish_job("six");

    // Saturation both ways.
    start_job(5'd0);
    expect_write(4'd0, 64'h0000_0000_8000_7FFF);
    send(32'h0001_0000, 1'b0);
    send(-32'sd70000, 1'b1);
    check("sat_set", 64'(sat), 64'd1);
    finish_job("sat");

    // Rounding with shift 1; start clears sat.
    start_job(5'd1);
    check("sat_cleared", 64'(sat), 64'd0);
    expect_write(4'd0, 64'h0000_0000_FFFF_0002);
    send(32'd3, 1'b0);
    send(-32'sd3, 1'b1);
    check("round_nosat", 64'(sat), 64'd0);
    finish_job("round");

    // Rounding pushes the value over the top with shift 4.
    start_job(5'd4);
    expect_write(4'd0, 64'h0000_0000_0000_7FFF);
    send(32'h7FFF_FFF8, 1'b1);
    check("shift4_sat", 64'(sat), 64'd1);
    finish_job("shift4");

    // 68 elements: 17 writes, the 17th wraps to address 0.
    start_job(5'd0);
    for (int k = 0; k < 17; k++) begin
      expect_write(4'(k), {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)});
    end
    for (int i = 0; i < 68; i++) send(32'(i), (i == 67));
    finish_job("wrap");

    // Reset in the middle of a job discards the partial word.
    start_job(5'd0);
    send(32'd5, 1'b0);
    send(32'd6, 1'b0);
    RSTN = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 2; i++) begin
      acc_valid = 1'b1;
      start     = 1'b1;
      tick();
    end
    acc_valid = 1'b0;
    start     = 1'b0;
    RSTN      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      acc_valid = 1'b1;
      acc_last  = 1'b1;
      tick();
    end
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    check("midreset_idle_busy", 64'(busy), 64'd0);
    start_job(5'd0);
    expect_write(4'd0, 64'h0000_0000_0000_0042);
    send(32'h42, 1'b1);
    finish_job("after_reset");

    tick();
    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
